// File: rtl/operand_stack.sv
// Operand stack with single-cycle PUSH/POP/REPLACE/BINOP/CLEAR commands.
// Top/next-on-stack are read combinationally so they track the count register exactly.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               cmd,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         tos,
    output logic [WIDTH-1:0]         nos,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     done,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] TWO        = CW'(2);

    localparam logic [2:0] CMD_PUSH    = 3'b001;
    localparam logic [2:0] CMD_POP     = 3'b010;
    localparam logic [2:0] CMD_REPLACE = 3'b011;
    localparam logic [2:0] CMD_BINOP   = 3'b100;
    localparam logic [2:0] CMD_CLEAR   = 3'b101;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_reg, count_next;
    logic             done_reg, done_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    below_addr;

    // Modulo-DEPTH addressing: at count==DEPTH the low bits are 0, so top_addr wraps to DEPTH-1.
    assign top_addr   = count_reg[AW-1:0] - AW'(1);
    assign below_addr = count_reg[AW-1:0] - AW'(2);

    always_comb begin
        count_next     = count_reg;
        done_next      = 1'b0;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        we             = 1'b0;
        waddr          = count_reg[AW-1:0];
        case (cmd)
            CMD_PUSH: begin
                if (count_reg == FULL_COUNT) begin
                    overflow_next = 1'b1;
                end else begin
                    we         = 1'b1;
                    waddr      = count_reg[AW-1:0];
                    count_next = count_reg + ONE;
                    done_next  = 1'b1;
                end
            end
            CMD_POP: begin
                if (count_reg == '0) begin
                    underflow_next = 1'b1;
                end else begin
                    count_next = count_reg - ONE;
                    done_next  = 1'b1;
                end
            end
            CMD_REPLACE: begin
                if (count_reg == '0) begin
                    underflow_next = 1'b1;
                end else begin
                    we        = 1'b1;
                    waddr     = top_addr;
                    done_next = 1'b1;
                end
            end
            CMD_BINOP: begin
                if (count_reg < TWO) begin
                    underflow_next = 1'b1;
                end else begin
                    we         = 1'b1;
                    waddr      = below_addr;
                    count_next = count_reg - ONE;
                    done_next  = 1'b1;
                end
            end
            CMD_CLEAR: begin
                count_next     = '0;
                overflow_next  = 1'b0;
                underflow_next = 1'b0;
                done_next      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg     <= '0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            done_reg      <= done_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is not reset; entries above count are never presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    assign tos       = (count_reg != '0) ? mem[top_addr] : '0;
    assign nos       = (count_reg >= TWO) ? mem[below_addr] : '0;
    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);
    assign done      = done_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_operand_stack.sv
// Directed-vector bench for operand_stack: stimulus queues expected results,
// a monitor process pops and compares one transaction per clock.
module tb_operand_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    localparam logic [2:0] NOP     = 3'b000;
    localparam logic [2:0] PUSH    = 3'b001;
    localparam logic [2:0] POP     = 3'b010;
    localparam logic [2:0] REPLACE = 3'b011;
    localparam logic [2:0] BINOP   = 3'b100;
    localparam logic [2:0] CLEAR   = 3'b101;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       cmd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             done;
    logic             overflow;
    logic             underflow;

    typedef struct packed {
        logic [2:0]       cmd;
        logic [WIDTH-1:0] tos;
        logic [WIDTH-1:0] nos;
        logic [CW-1:0]    count;
        logic             done;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .din       (din),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .done      (done),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".tos"},       32'(tos),       32'(e.tos));
        check({tag, ".nos"},       32'(nos),       32'(e.nos));
        check({tag, ".count"},     32'(count),     32'(e.count));
        check({tag, ".empty"},     32'(empty),     32'(e.count == 0));
        check({tag, ".full"},      32'(full),      32'(e.count == DEPTH));
        check({tag, ".done"},      32'(done),      32'(e.done));
        check({tag, ".overflow"},  32'(overflow),  32'(e.ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(e.unf));
    endtask

    // Drive one command for one clock and queue the hand-computed result.
    task automatic issue(input logic [2:0] c, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] n,
                         input logic [CW-1:0] cnt, input logic dn,
                         input logic ov, input logic un);
        exp_t e;
        e.cmd = c; e.tos = t; e.nos = n; e.count = cnt;
        e.done = dn; e.ovf = ov; e.unf = un;
        cmd = c;
        din = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd = NOP;
    endtask

    // Monitor: a command pending at a rising edge is checked 2 time units later.
    initial begin
        int   pending;
        exp_t e;
        forever begin
            @(posedge clk);
            pending = exp_q.size();
            #2;
            if (pending > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: cmd=%0d tos=%0d nos=%0d count=%0d done=%0b ovf=%0b unf=%0b",
                         n_txn, e.cmd, tos, nos, count, done, overflow, underflow);
                check_outputs($sformatf("txn%0d", n_txn), e);
            end
        end
    end

    initial begin
        exp_t zero;
        zero = '0;
        reset = 1'b0;
        cmd   = NOP;
        din   = '0;
        #3;
        check_outputs("reset_state", zero);

        // Command held during reset must be ignored.
        cmd = PUSH; din = 8'd42;
        @(posedge clk);
        #1;
        check_outputs("push_in_reset", zero);
        @(negedge clk);
        reset = 1'b1;
        cmd   = NOP;
        @(posedge clk);
        #1;

        // Push two, combine, pop.
        issue(PUSH,  8'd5,  8'd5,  8'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        issue(PUSH,  8'd7,  8'd7,  8'd5, 5'd2, 1'b1, 1'b0, 1'b0);
        issue(BINOP, 8'd12, 8'd12, 8'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        issue(POP,   8'd0,  8'd0,  8'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        issue(NOP,   8'd0,  8'd0,  8'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Underflow behaviour and CLEAR.
        issue(POP,     8'd0, 8'd0, 8'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(REPLACE, 8'd9, 8'd0, 8'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(PUSH,    8'd3, 8'd3, 8'd0, 5'd1, 1'b1, 1'b0, 1'b1);
        issue(BINOP,   8'd6, 8'd3, 8'd0, 5'd1, 1'b0, 1'b0, 1'b1);
        issue(CLEAR,   8'd0, 8'd0, 8'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // REPLACE and reserved opcodes.
        issue(PUSH,    8'd5,  8'd5, 8'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        issue(REPLACE, 8'd8,  8'd8, 8'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        issue(3'b111,  8'd77, 8'd8, 8'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        issue(3'b110,  8'd66, 8'd8, 8'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        issue(CLEAR,   8'd0,  8'd0, 8'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Fill to DEPTH, then overflow.
        for (int i = 1; i <= DEPTH; i++) begin
            issue(PUSH, 8'(i), 8'(i), 8'(i - 1), 5'(i), 1'b1, 1'b0, 1'b0);
        end
        issue(PUSH,  8'd99, 8'd16, 8'd15, 5'd16, 1'b0, 1'b1, 1'b0);
        issue(POP,   8'd0,  8'd15, 8'd14, 5'd15, 1'b1, 1'b1, 1'b0);
        issue(BINOP, 8'd50, 8'd50, 8'd13, 5'd14, 1'b1, 1'b1, 1'b0);
        issue(CLEAR, 8'd0,  8'd0,  8'd0,  5'd0,  1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges.
        issue(PUSH, 8'd1, 8'd1, 8'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        issue(PUSH, 8'd2, 8'd2, 8'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        issue(PUSH, 8'd3, 8'd3, 8'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs("async_reset", zero);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(PUSH, 8'd4, 8'd4, 8'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        issue(NOP,  8'd0, 8'd4, 8'd0, 5'd1, 1'b0, 1'b0, 1'b0);

        // Bounded drain of the scoreboard.
        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each stack entry.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd  input  3  command: 000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 BINOP, 101 CLEAR, 110/111 treated as NOP.
REQ-006 SHALL have port din  input  WIDTH  value written by PUSH, REPLACE, BINOP.
REQ-007 SHALL have port tos  output  WIDTH  current top-of-stack entry.
REQ-008 SHALL have port nos  output  WIDTH  entry directly below top.
REQ-009 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.
REQ-010 SHALL have port empty  output  1  high when count==0.
REQ-011 SHALL have port full  output  1  high when count==DEPTH.
REQ-012 SHALL have port done  output  1  one-cycle pulse, command accepted.
REQ-013 SHALL have port overflow  output  1  sticky, PUSH attempted while full.
REQ-014 SHALL have port underflow  output  1  sticky, entry removal attempted with too few entries.

Function
REQ-015 SHALL sample cmd/din every rising edge; a command occupies exactly one cycle; new state is visible on outputs in the following cycle (latency 1).
REQ-016 PUSH with count<DEPTH SHALL write din at entry position count, then count+1.
REQ-017 POP with count>=1 SHALL decrement count; popped entry's storage is not cleared.
REQ-018 REPLACE with count>=1 SHALL overwrite the top entry with din; count unchanged.
REQ-019 BINOP with count>=2 SHALL write din into the nos position, then count-1 (consume two operands, push one result).
REQ-020 CLEAR SHALL set count to 0 and clear overflow and underflow; done pulses.
REQ-021 PUSH while full SHALL leave storage and count unchanged, set overflow, not pulse done.
REQ-022 POP or REPLACE while empty, and BINOP with count<2, SHALL leave state unchanged, set underflow, not pulse done.
REQ-023 Accepted PUSH/POP/REPLACE/BINOP SHALL pulse done for exactly one cycle; NOP and rejected commands SHALL hold done low.
REQ-024 tos SHALL equal entry count-1 when count>=1, else 0; nos SHALL equal entry count-2 when count>=2, else 0.
REQ-025 Count arithmetic SHALL never wrap: count stays within 0..DEPTH under any command sequence.
REQ-026 overflow/underflow SHALL remain set until CLEAR or reset; a rejected command SHALL not alter the other flag.
REQ-027 empty and full SHALL be decoded from the count register, never from the incoming cmd.

Reset
REQ-028 reset low SHALL immediately, without a clock, force count=0, empty=1, full=0, done=0, overflow=0, underflow=0, tos=0, nos=0.
REQ-029 Stack storage contents need not be cleared on reset; they are unobservable while count=0.
REQ-030 reset asserted mid-command SHALL abort it; the first command after reset deassertion is sampled on the next rising edge.

Verification
REQ-031 Reset, PUSH 5, PUSH 7 -> tos=7, nos=5, count=2, done pulsed twice, empty=0.
REQ-032 From {5,7}: BINOP din=12 -> tos=12, nos=0, count=1; then POP -> count=0, empty=1, tos=0.
REQ-033 DEPTH=16: 16 PUSHes of 1..16 -> full=1, tos=16; 17th PUSH 99 -> tos=16, count=16, overflow=1, no done.
REQ-034 Empty stack: POP -> underflow=1, count=0; PUSH 3 then BINOP -> underflow stays 1, tos=3, count=1; CLEAR -> flags 0, count=0.
REQ-035 From {5}: REPLACE din=8 -> tos=8, count=1, done pulse; cmd=111 -> no state change, done low.
REQ-036 Three PUSHes, reset low between clock edges -> count=0, empty=1 immediately; reset high then PUSH 4 -> tos=4, count=1.
